// File: rtl/i2c_tx_feeder.sv
// Frame buffer and launch sequencer feeding one I2C write frame into the pca9564 driver.
// Bytes are served to the driver with a one-byte lookahead so back-to-back data writes never repeat a byte.
module i2c_tx_feeder #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned PTR_W          = 4,
    parameter int unsigned LAUNCH_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       host_data,
    input  logic             host_push,
    input  logic             host_commit,
    output logic             host_ready,
    output logic [PTR_W:0]   fill_level,
    output logic             frame_done,
    output logic             err,
    output logic [7:0]       drv_data,
    output logic [7:0]       drv_len,
    output logic             drv_write_enable,
    input  logic             drv_busy,
    input  logic             drv_write_strobe,
    input  logic [1:0]       drv_addr
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(LAUNCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LAUNCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LAUNCH,
        WAIT_BUSY,
        SEND,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       len_q, len_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             we_q, we_d;
    logic             ready_q, ready_d;

    logic [7:0]       mem_q [DEPTH];
    logic             wr_en_c;
    logic [PTR_W-1:0] wr_ptr_c;
    logic             consume_c;
    logic [7:0]       look_c;
    logic [PTR_W-1:0] rd_ptr_c;

    // Driver data-register write seen this cycle
    assign consume_c = (drv_write_strobe == 1'b0) && (drv_addr == 2'b01);

    // Next-state, counters and registered-output targets
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        rd_d     = rd_q;
        tmo_d    = tmo_q;
        len_d    = len_q;
        err_d    = err_q;
        wr_en_c  = 1'b0;
        wr_ptr_c = PTR_W'(fill_q);

        case (state_q)
            IDLE: begin
                if (host_push) begin
                    if (fill_q < FULL) begin
                        wr_en_c = 1'b1;
                        fill_d  = fill_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A byte pushed alongside the commit is already counted in fill_d
                if (host_commit && (fill_d != '0)) begin
                    len_d   = 8'(fill_d);
                    err_d   = 1'b0;
                    rd_d    = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!drv_busy) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (drv_busy) begin
                    state_d = SEND;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ARM;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            SEND: begin
                if (consume_c) begin
                    if (8'(rd_q) == len_q) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d = rd_q + CNT_W'(1);
                    end
                end
                if (!drv_busy) begin
                    if (8'(rd_d) != len_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                fill_d  = '0;
                rd_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && (host_push || host_commit)) begin
            err_d = 1'b1;
        end

        ready_d = (state_d == IDLE) && (fill_d < FULL);
        done_d  = (state_d == DONE);
        we_d    = (state_d != LAUNCH);
    end

    // Lookahead read: during a consume cycle the driver must already see the next byte
    always_comb begin
        look_c = 8'(rd_q) + 8'(consume_c && (state_q == SEND));
        if (look_c >= len_q) begin
            look_c = len_q - 8'd1;
        end
        rd_ptr_c = PTR_W'(look_c);
        drv_data = (state_q == IDLE) ? 8'h00 : mem_q[rd_ptr_c];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            fill_q  <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= done_d;
            we_q    <= we_d;
            ready_q <= ready_d;
        end
    end

    // Frame storage; contents are only meaningful below fill_level
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_c] <= host_data;
        end
    end

    assign host_ready       = ready_q;
    assign fill_level       = fill_q;
    assign frame_done       = done_q;
    assign err              = err_q;
    assign drv_len          = len_q;
    assign drv_write_enable = we_q;

endmodule
